// File: rtl/memacc_fifo_if.sv
// Bundles the MEMACC FIFO read port and the memory write port.
// The master modport is the sequencer side; the slave modport is the FIFO and memory side.
interface memacc_fifo_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fifo_rd_req_o;
  logic              fifo_rd_empty_i;
  logic              fifo_ad_sel_i;
  logic [31:0]       fifo_ad_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_we_o;
  logic              mem_ack_i;

  modport master (
    output fifo_rd_req_o, mem_addr_o, mem_data_o, mem_we_o,
    input  fifo_rd_empty_i, fifo_ad_sel_i, fifo_ad_i, mem_ack_i
  );

  modport slave (
    input  fifo_rd_req_o, mem_addr_o, mem_data_o, mem_we_o,
    output fifo_rd_empty_i, fifo_ad_sel_i, fifo_ad_i, mem_ack_i
  );
endinterface

// File: rtl/memacc_fifo_sequencer.sv
// Drains the MEMACC host->device FIFO and turns address/data entries into memory writes.
// Data words go to the current address, which then auto-increments.
module memacc_fifo_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_sys_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          clr_status_i,
  memacc_fifo_if.master bus_if,
  output logic          busy_o,
  output logic [15:0]   wr_count_o,
  output logic          err_noaddr_o,
  output logic          err_timeout_o
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit HAS_TIMEOUT = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_LATCH = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic              err_noaddr_q, err_noaddr_d;
  logic              err_timeout_q, err_timeout_d;
  logic              done_s, noaddr_set_s, timeout_set_s;
  logic              unused_ad_s;

  assign unused_ad_s = ^bus_if.fifo_ad_i;

  // Next-state, datapath and status update logic
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    addr_valid_d  = addr_valid_q;
    data_d        = data_q;
    wait_d        = {WAIT_W{1'b0}};
    done_s        = 1'b0;
    noaddr_set_s  = 1'b0;
    timeout_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && !bus_if.fifo_rd_empty_i) state_d = ST_READ;
        else                                     state_d = ST_IDLE;
      end
      ST_READ: state_d = ST_LATCH;
      ST_LATCH: begin
        if (!bus_if.fifo_ad_sel_i) begin
          addr_d       = bus_if.fifo_ad_i[ADDR_W-1:0];
          addr_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (addr_valid_q) begin
          data_d  = bus_if.fifo_ad_i[DATA_W-1:0];
          state_d = ST_WRITE;
        end else begin
          noaddr_set_s = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // An ack in the expiry cycle still completes the write
        if (bus_if.mem_ack_i) begin
          addr_d  = addr_q + ADDR_W'(1);
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else if (HAS_TIMEOUT && (wait_q == WAIT_LAST)) begin
          timeout_set_s = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
          state_d = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_s)            wr_count_d = clr_status_i ? 16'd1 :
                                        ((wr_count_q == 16'hFFFF) ? 16'hFFFF : wr_count_q + 16'd1);
    else if (clr_status_i) wr_count_d = 16'd0;
    else                   wr_count_d = wr_count_q;

    if (noaddr_set_s)      err_noaddr_d = 1'b1;
    else if (clr_status_i) err_noaddr_d = 1'b0;
    else                   err_noaddr_d = err_noaddr_q;

    if (timeout_set_s)     err_timeout_d = 1'b1;
    else if (clr_status_i) err_timeout_d = 1'b0;
    else                   err_timeout_d = err_timeout_q;
  end

  // State and datapath registers
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      addr_q        <= {ADDR_W{1'b0}};
      addr_valid_q  <= 1'b0;
      data_q        <= {DATA_W{1'b0}};
      wait_q        <= {WAIT_W{1'b0}};
      wr_count_q    <= 16'd0;
      err_noaddr_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      addr_valid_q  <= addr_valid_d;
      data_q        <= data_d;
      wait_q        <= wait_d;
      wr_count_q    <= wr_count_d;
      err_noaddr_q  <= err_noaddr_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus_if.fifo_rd_req_o = (state_q == ST_READ);
  assign bus_if.mem_we_o      = (state_q == ST_WRITE);
  assign bus_if.mem_addr_o    = addr_q;
  assign bus_if.mem_data_o    = data_q;
  assign busy_o               = (state_q != ST_IDLE);
  assign wr_count_o           = wr_count_q;
  assign err_noaddr_o         = err_noaddr_q;
  assign err_timeout_o        = err_timeout_q;

endmodule
